systolic_pe_dbuf: RTL and testbench

Parametrised second-generation systolic-array processing element. It adds the following over the single-mode, single-weight PE:
- a double-buffered (shadow/active) weight with daisy-chain loading;
- a runtime-selectable weight-stationary (WS) or output-stationary (OS) dataflow;
- explicit valid propagation;
- signed/unsigned arithmetic;
- optional saturation with a sticky overflow flag.

---
 rtl/systolic_pe_dbuf.sv | 88 ++++++++
 tb/tb_systolic_pe_dbuf.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_pe_dbuf.sv
// systolic_pe_dbuf: double-buffered-weight systolic PE with WS/OS dataflow, valid chain and optional saturation
module systolic_pe_dbuf #(
    parameter int DATA_WIDTH   = 16,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACCUM_WIDTH  = 32,
    parameter bit SIGNED       = 1'b1,
    parameter bit SATURATE     = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    mode,
    input  logic [DATA_WIDTH-1:0]   act_in,
    input  logic                    act_valid_in,
    output logic [DATA_WIDTH-1:0]   act_out,
    output logic                    act_valid_out,
    input  logic [WEIGHT_WIDTH-1:0] w_in,
    input  logic                    w_load,
    output logic [WEIGHT_WIDTH-1:0] w_out,
    input  logic                    w_swap,
    input  logic [ACCUM_WIDTH-1:0]  psum_in,
    input  logic                    psum_valid_in,
    output logic [ACCUM_WIDTH-1:0]  psum_out,
    output logic                    psum_valid_out,
    input  logic                    acc_last,
    output logic [ACCUM_WIDTH-1:0]  acc_out,
    output logic                    acc_out_valid,
    output logic                    ovf,
    input  logic                    ovf_clear
);
    localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;
    logic [WEIGHT_WIDTH-1:0] w_act;
    logic [PW-1:0] prod;
    logic [ACCUM_WIDTH-1:0] prod_ext, prod_r, psum_r, acc, ws_sum, os_sum;
    logic psum_v_r, last_r, ws_ovf, os_ovf, ovf_set;
    function automatic logic [ACCUM_WIDTH:0] add(input logic [ACCUM_WIDTH-1:0] a, input logic [ACCUM_WIDTH-1:0] b);
        logic [ACCUM_WIDTH:0] s;
        logic o;
        logic [ACCUM_WIDTH-1:0] lim;
        s = {SIGNED && a[ACCUM_WIDTH-1], a} + {SIGNED && b[ACCUM_WIDTH-1], b};
        o = SIGNED ? s[ACCUM_WIDTH] ^ s[ACCUM_WIDTH-1] : s[ACCUM_WIDTH];
        lim = SIGNED ? {s[ACCUM_WIDTH], {(ACCUM_WIDTH-1){~s[ACCUM_WIDTH]}}} : '1;
        return {o, (SATURATE && o) ? lim : s[ACCUM_WIDTH-1:0]};
    endfunction
    assign prod = {{WEIGHT_WIDTH{SIGNED && act_in[DATA_WIDTH-1]}}, act_in}
                * {{DATA_WIDTH{SIGNED && w_act[WEIGHT_WIDTH-1]}}, w_act};
    assign prod_ext = ACCUM_WIDTH'(prod) | ({ACCUM_WIDTH{SIGNED && prod[PW-1]}} << PW);
    assign {ws_ovf, ws_sum} = add(psum_r, act_valid_out ? prod_r : '0);
    assign {os_ovf, os_sum} = add(acc, prod_r);
    assign ovf_set = mode ? act_valid_out && os_ovf : (act_valid_out || psum_v_r) && ws_ovf;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_out          <= '0;
            w_act          <= '0;
            act_out        <= '0;
            act_valid_out  <= 1'b0;
            prod_r         <= '0;
            psum_r         <= '0;
            psum_v_r       <= 1'b0;
            last_r         <= 1'b0;
            psum_out       <= '0;
            psum_valid_out <= 1'b0;
            acc            <= '0;
            acc_out        <= '0;
            acc_out_valid  <= 1'b0;
            ovf            <= 1'b0;
        end else begin
            ovf <= ovf_clear ? 1'b0 : ovf | (en && ovf_set);
            if (en) begin
                w_out          <= w_load ? w_in : w_out;
                w_act          <= w_swap ? w_out : w_act;
                act_out        <= act_in;
                act_valid_out  <= act_valid_in;
                prod_r         <= prod_ext;
                psum_r         <= psum_in;
                psum_v_r       <= psum_valid_in;
                last_r         <= acc_last;
                psum_out       <= mode ? psum_r : ws_sum;
                psum_valid_out <= psum_v_r | (!mode & act_valid_out);
                acc_out_valid  <= mode & act_valid_out & last_r;
                if (mode && act_valid_out) begin
                    acc     <= last_r ? '0 : os_sum;
                    acc_out <= last_r ? os_sum : acc_out;
                end
            end
        end
    end
endmodule

// File: tb/tb_systolic_pe_dbuf.sv
// tb_systolic_pe_dbuf: scoreboard bench driving a saturating and a wrapping PE side by side
module tb_systolic_pe_dbuf;
    localparam int AW = 24;
    logic clk = 1'b0, rst_n = 1'b1, en = 1'b0, mode = 1'b0;
    logic act_valid_in = 1'b0, w_load = 1'b0, w_swap = 1'b0, psum_valid_in = 1'b0, acc_last = 1'b0, ovf_clear = 1'b0;
    logic [15:0] act_in = '0;
    logic [7:0] w_in = '0;
    logic [AW-1:0] psum_in = '0;
    logic [15:0] s_act_out, r_act_out;
    logic [7:0] s_w_out, r_w_out;
    logic [AW-1:0] s_psum_out, r_psum_out, s_acc_out, r_acc_out;
    logic s_act_valid_out, r_act_valid_out, s_psum_valid_out, r_psum_valid_out;
    logic s_acc_out_valid, r_acc_out_valid, s_ovf, r_ovf;
    int checks = 0, errors = 0;
    logic adv;
    typedef struct {logic [AW-1:0] s; logic [AW-1:0] r;} exp_t;
    exp_t pq[$], aq[$];
    exp_t mx;
    longint sh = 0, act_w = 0, macc_s = 0, macc_r = 0;

    systolic_pe_dbuf #(.DATA_WIDTH(16), .WEIGHT_WIDTH(8), .ACCUM_WIDTH(AW), .SIGNED(1'b1), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .act_in(act_in), .act_valid_in(act_valid_in), .act_out(s_act_out), .act_valid_out(s_act_valid_out),
        .w_in(w_in), .w_load(w_load), .w_out(s_w_out), .w_swap(w_swap),
        .psum_in(psum_in), .psum_valid_in(psum_valid_in), .psum_out(s_psum_out), .psum_valid_out(s_psum_valid_out),
        .acc_last(acc_last), .acc_out(s_acc_out), .acc_out_valid(s_acc_out_valid), .ovf(s_ovf), .ovf_clear(ovf_clear));

    systolic_pe_dbuf #(.DATA_WIDTH(16), .WEIGHT_WIDTH(8), .ACCUM_WIDTH(AW), .SIGNED(1'b1), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .act_in(act_in), .act_valid_in(act_valid_in), .act_out(r_act_out), .act_valid_out(r_act_valid_out),
        .w_in(w_in), .w_load(w_load), .w_out(r_w_out), .w_swap(w_swap),
        .psum_in(psum_in), .psum_valid_in(psum_valid_in), .psum_out(r_psum_out), .psum_valid_out(r_psum_valid_out),
        .acc_last(acc_last), .acc_out(r_acc_out), .acc_out_valid(r_acc_out_valid), .ovf(r_ovf), .ovf_clear(ovf_clear));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint clampv(input longint v);
        if (v > 64'sd8388607) return 64'sd8388607;
        if (v < -64'sd8388608) return -64'sd8388608;
        return v;
    endfunction

    task automatic step(input logic e, input logic m, input logic av, input logic [15:0] a, input logic pv,
                        input logic [AW-1:0] p, input logic wl, input logic [7:0] wi, input logic ws, input logic al);
        longint pr, v;
        exp_t x;
        en = e; mode = m; act_valid_in = av; act_in = a; psum_valid_in = pv; psum_in = p;
        w_load = wl; w_in = wi; w_swap = ws; acc_last = al;
        if (e) begin
            pr = av ? longint'($signed(a)) * act_w : 64'sd0;
            if (!m && (av || pv)) begin
                v = longint'($signed(p)) + pr;
                x.s = AW'(clampv(v));
                x.r = AW'(v);
                pq.push_back(x);
            end
            if (m && pv) begin
                x.s = p;
                x.r = p;
                pq.push_back(x);
            end
            if (m && av) begin
                macc_s = clampv(macc_s + pr);
                macc_r = macc_r + pr;
                if (al) begin
                    x.s = AW'(macc_s);
                    x.r = AW'(macc_r);
                    aq.push_back(x);
                    macc_s = 0;
                    macc_r = 0;
                end
            end
            if (ws) act_w = sh;
            if (wl) sh = longint'($signed(wi));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic m);
        repeat (n) step(1'b1, m, 1'b0, 16'd0, 1'b0, '0, 1'b0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic setw(input logic [7:0] wv);
        step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, '0, 1'b1, wv, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, '0, 1'b0, 8'd0, 1'b1, 1'b0);
    endtask

    // outputs only change on edges that advanced, so only those are scored
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) adv <= 1'b0;
        else adv <= en;
    end

    always @(negedge clk) begin
        if (adv && s_psum_valid_out) begin
            if (pq.size() == 0) chk("psum_extra", 1, 0);
            else begin
                mx = pq.pop_front();
                chk("psum_sat", s_psum_out, mx.s);
                chk("psum_wrap", r_psum_out, mx.r);
            end
        end
        if (adv && s_acc_out_valid) begin
            if (aq.size() == 0) chk("acc_extra", 1, 0);
            else begin
                mx = aq.pop_front();
                chk("acc_sat", s_acc_out, mx.s);
                chk("acc_wrap", r_acc_out, mx.r);
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        #10;
        chk("rst_psum", s_psum_out, 0);
        chk("rst_psum_v", s_psum_valid_out, 0);
        chk("rst_act", s_act_out, 0);
        chk("rst_w_out", s_w_out, 0);
        chk("rst_acc", s_acc_out, 0);
        chk("rst_ovf", s_ovf, 0);
        @(negedge clk) rst_n = 1'b1;
        // WS basic: -3 * 100 + 1000
        setw(8'hFD);
        step(1, 0, 1, 16'd100, 1, 24'd1000, 0, 0, 0, 0);
        chk("ws_act_out", s_act_out, 100);
        chk("ws_act_v", s_act_valid_out, 1);
        idle(1, 0);
        chk("ws_psum", s_psum_out, 700);
        chk("ws_psum_v", s_psum_valid_out, 1);
        idle(2, 0);
        // double buffer: load 5 while active=2, swap one cycle later
        setw(8'd2);
        step(1, 0, 1, 16'd10, 0, '0, 1, 8'd5, 0, 0);
        chk("dbuf_w_out", s_w_out, 5);
        step(1, 0, 1, 16'd10, 0, '0, 0, 8'd0, 1, 0);
        step(1, 0, 1, 16'd10, 0, '0, 0, 8'd0, 0, 0);
        step(1, 0, 1, 16'd10, 0, '0, 0, 8'd0, 0, 0);
        step(1, 0, 0, 16'd0, 0, '0, 1, 8'd7, 1, 0);
        step(1, 0, 1, 16'd1, 0, '0, 0, 8'd0, 0, 0);
        idle(3, 0);
        // OS accumulate
        setw(8'd4);
        idle(2, 0);
        step(1, 1, 1, 16'd1, 0, '0, 0, 0, 0, 0);
        step(1, 1, 1, 16'd2, 0, '0, 0, 0, 0, 0);
        step(1, 1, 1, 16'd3, 0, '0, 0, 0, 0, 1);
        idle(1, 1);
        chk("os_strobe", s_acc_out_valid, 1);
        chk("os_acc24", s_acc_out, 24);
        idle(1, 1);
        chk("os_strobe_drop", s_acc_out_valid, 0);
        chk("os_acc_hold", s_acc_out, 24);
        step(1, 1, 0, 16'd0, 0, '0, 0, 0, 0, 1);
        step(1, 1, 1, 16'd1, 0, '0, 0, 0, 0, 1);
        idle(1, 1);
        chk("os_acc4", s_acc_out, 4);
        step(1, 1, 0, 16'd0, 1, 24'd123, 0, 0, 0, 0);
        idle(2, 1);
        idle(2, 0);
        // positive saturation vs wrap
        setw(8'd127);
        step(1, 0, 1, 16'd127, 1, 24'd8388600, 0, 0, 0, 0);
        idle(1, 0);
        chk("sat_pos", s_psum_out, 8388607);
        chk("wrap_pos", r_psum_out, 8404729);
        chk("ovf_sat", s_ovf, 1);
        chk("ovf_wrap", r_ovf, 1);
        idle(1, 0);
        ovf_clear = 1'b1;
        en = 1'b0;
        @(posedge clk);
        #1;
        ovf_clear = 1'b0;
        chk("ovf_clr_stalled", s_ovf, 0);
        chk("ovf_clr_wrap", r_ovf, 0);
        // negative saturation with clear winning over the set
        setw(8'h80);
        step(1, 0, 1, 16'd32767, 1, AW'(-5000000), 0, 0, 0, 0);
        ovf_clear = 1'b1;
        idle(1, 0);
        ovf_clear = 1'b0;
        chk("sat_neg", s_psum_out, 24'h800000);
        chk("wrap_neg", r_psum_out, 7583040);
        chk("ovf_clr_prio", s_ovf, 0);
        idle(1, 0);
        // stall mid-stream
        setw(8'd3);
        step(1, 0, 1, 16'd1, 1, 24'd10, 0, 0, 0, 0);
        step(1, 0, 1, 16'd2, 1, 24'd10, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 16'd99, 1, 24'd5, 1, 8'd9, 1, 1);
            chk("stall_act", s_act_out, 2);
            chk("stall_psum", s_psum_out, 13);
            chk("stall_psum_v", s_psum_valid_out, 1);
        end
        step(1, 0, 1, 16'd3, 1, 24'd10, 0, 0, 0, 0);
        step(1, 0, 1, 16'd4, 1, 24'd10, 0, 0, 0, 0);
        idle(3, 0);
        chk("stall_w_out", s_w_out, 3);
        // asynchronous reset mid-stream
        step(1, 0, 1, 16'd5, 1, 24'd0, 0, 0, 0, 0);
        step(1, 0, 1, 16'd6, 1, 24'd0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_psum", s_psum_out, 0);
        chk("arst_psum_v", s_psum_valid_out, 0);
        chk("arst_act", s_act_out, 0);
        chk("arst_act_v", s_act_valid_out, 0);
        chk("arst_w_out", s_w_out, 0);
        chk("arst_acc", s_acc_out, 0);
        chk("arst_wrap_psum", r_psum_out, 0);
        pq.delete();
        aq.delete();
        sh = 0;
        act_w = 0;
        macc_s = 0;
        macc_r = 0;
        @(negedge clk) rst_n = 1'b1;
        step(1, 0, 1, 16'd50, 1, 24'd7, 0, 0, 0, 0);
        idle(1, 0);
        chk("arst_weight0", s_psum_out, 7);
        idle(3, 0);
        chk("sb_drain", pq.size() + aq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
